// File: rtl/bp_mem_responder_pkg.sv
// Shared memory-message types for the cce mem interface responder: message/size enums,
// responder FSM states and a header struct macro sized by address and payload widths.

`define DECLARE_BP_MEM_HEADER_S(paddr_width_mp, payload_width_mp) \
  typedef struct packed {                                        \
    logic [payload_width_mp-1:0] payload;                        \
    logic [paddr_width_mp-1:0]   addr;                           \
    bp_mem_msg_size_e            size;                           \
    bp_mem_msg_e                 msg_type;                       \
  } bp_mem_header_s

package bp_me_pkg;

  localparam int mem_msg_type_width = 4;
  localparam int mem_size_width     = 3;

  typedef enum logic [mem_msg_type_width-1:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3,
    e_mem_msg_pre   = 4'd4,
    e_mem_msg_amo   = 4'd5
  } bp_mem_msg_e;

  typedef enum logic [mem_size_width-1:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_wait  = 2'd1,
    e_resp  = 2'd2
  } bp_mem_responder_state_e;

  function automatic logic is_write(input bp_mem_msg_e msg_type);
    return (msg_type == e_mem_msg_wr) || (msg_type == e_mem_msg_uc_wr);
  endfunction

  function automatic logic is_read(input bp_mem_msg_e msg_type);
    return (msg_type == e_mem_msg_rd) || (msg_type == e_mem_msg_uc_rd);
  endfunction

endpackage

// File: rtl/bp_mem_responder_if.sv
// Command (ready/valid) and response (valid/yumi) channels between a cache engine and
// the memory responder; message layout is {data, payload, addr, size, msg_type}.

interface bp_mem_responder_if
  import bp_me_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16
);

  localparam int mem_msg_width = block_width_p + payload_width_p + paddr_width_p
                               + mem_size_width + mem_msg_type_width;

  logic [mem_msg_width-1:0] mem_cmd_i;
  logic                     mem_cmd_v_i;
  logic                     mem_cmd_ready_o;
  logic [mem_msg_width-1:0] mem_resp_o;
  logic                     mem_resp_v_o;
  logic                     mem_resp_yumi_i;

  modport slave (
    input  mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
  );

  modport master (
    output mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
  );

endinterface

// File: rtl/bp_mem_responder_storage.sv
// Single-port block store: one read or one byte-masked write per cycle, registered read data.

module bp_mem_responder_storage #(
  parameter int els_p   = 64,
  parameter int width_p = 512
) (
  input  logic                             clk_i,
  input  logic                             v_i,
  input  logic                             w_i,
  input  logic [$clog2(els_p)-1:0]         addr_i,
  input  logic [width_p/8-1:0][7:0]        data_i,
  input  logic [width_p/8-1:0]             w_mask_i,
  output logic [width_p/8-1:0][7:0]        data_o
);

  logic [width_p/8-1:0][7:0] mem_r [els_p];

  // NOTE: the array and its read register carry no reset; contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) begin
        for (int b = 0; b < width_p/8; b++) begin
          if (w_mask_i[b]) mem_r[addr_i][b] <= data_i[b];
        end
      end else begin
        data_o <= mem_r[addr_i];
      end
    end
  end

endmodule

// File: rtl/bp_mem_responder.sv
// Test-memory responder: accepts one command, touches the block store, and returns a
// response after latency_p extra cycles, holding it until the consumer yumis it.

module bp_mem_responder
  import bp_me_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  parameter int mem_els_p       = 64,
  parameter int latency_p       = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_mem_responder_if.slave     mem_if
);

  localparam int block_bytes = block_width_p / 8;
  localparam int lg_bb       = $clog2(block_bytes);
  localparam int lg_els      = $clog2(mem_els_p);
  localparam int cnt_width   = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  `DECLARE_BP_MEM_HEADER_S(paddr_width_p, payload_width_p);

  bp_mem_header_s                 cmd_header, header_r;
  logic [block_bytes-1:0][7:0]    cmd_bytes, w_bytes, rd_bytes, resp_bytes;
  logic [block_bytes-1:0]         w_mask;
  logic [lg_bb-1:0]               w_cm, w_off, r_cm, r_off;
  logic [cnt_width-1:0]           count_r;
  bp_mem_responder_state_e        state_r, state_n;
  logic                           cmd_ready, resp_v, accept;

  assign {cmd_bytes, cmd_header} = mem_if.mem_cmd_i;
  assign accept = (state_r == e_ready) && mem_if.mem_cmd_v_i;

  // Byte-offset bits that fall inside one access; sizes at or above the block cover it all.
  function automatic logic [lg_bb-1:0] chunk_mask(input logic [2:0] size);
    if (int'(size) >= lg_bb) return '1;
    return lg_bb'((32'd1 << size) - 32'd1);
  endfunction

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= e_ready;
      count_r  <= '0;
      header_r <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        header_r <= cmd_header;
        count_r  <= cnt_width'(latency_p);
      end else if (state_r == e_wait) begin
        count_r  <= count_r - 1'b1;
      end
    end
  end

  // NOTE: defaults come first so no path leaves an output unassigned and infers a latch.
  always_comb begin
    state_n   = state_r;
    cmd_ready = 1'b0;
    resp_v    = 1'b0;
    unique case (state_r)
      e_ready: begin
        cmd_ready = 1'b1;
        if (mem_if.mem_cmd_v_i) state_n = (latency_p == 0) ? e_resp : e_wait;
      end
      e_wait: begin
        if (count_r == cnt_width'(1)) state_n = e_resp;
      end
      e_resp: begin
        resp_v = 1'b1;
        if (mem_if.mem_resp_yumi_i) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  // Write chunk is replicated across the block; the mask picks the aligned window.
  always_comb begin
    w_cm  = chunk_mask(cmd_header.size);
    w_off = cmd_header.addr[lg_bb-1:0] & ~w_cm;
    for (int i = 0; i < block_bytes; i++) begin
      w_bytes[i] = cmd_bytes[lg_bb'(i) & w_cm];
      w_mask[i]  = ((lg_bb'(i) & ~w_cm) == w_off);
    end
  end

  bp_mem_responder_storage #(
    .els_p   (mem_els_p),
    .width_p (block_width_p)
  ) storage (
    .clk_i    (clk_i),
    .v_i      (accept && (is_read(cmd_header.msg_type) || is_write(cmd_header.msg_type))),
    .w_i      (is_write(cmd_header.msg_type)),
    .addr_i   (cmd_header.addr[lg_bb +: lg_els]),
    .data_i   (w_bytes),
    .w_mask_i (w_mask),
    .data_o   (rd_bytes)
  );

  // Read data only shows while a read response is presented; the store output is stable then.
  always_comb begin
    r_cm       = chunk_mask(header_r.size);
    r_off      = header_r.addr[lg_bb-1:0] & ~r_cm;
    resp_bytes = '0;
    if ((state_r == e_resp) && is_read(header_r.msg_type)) begin
      for (int i = 0; i < block_bytes; i++) begin
        resp_bytes[i] = rd_bytes[r_off | (lg_bb'(i) & r_cm)];
      end
    end
  end

  assign mem_if.mem_cmd_ready_o = cmd_ready;
  assign mem_if.mem_resp_v_o    = resp_v;
  assign mem_if.mem_resp_o      = {resp_bytes, header_r};

  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
      mem_if.mem_resp_yumi_i |-> mem_if.mem_resp_v_o
  );

endmodule

// File: tb/tb_bp_mem_responder.sv
// Bench for bp_mem_responder: two instances (latency 4 and latency 0) driven with directed
// and random commands, checked against a byte-array memory model.

module tb_bp_mem_responder;

  localparam int PADDR   = 40;
  localparam int BLOCK   = 512;
  localparam int PAYLOAD = 16;
  localparam int ELS     = 64;
  localparam int BB      = BLOCK / 8;
  localparam int MSG_W   = BLOCK + PAYLOAD + PADDR + 7;
  localparam int LAT_A   = 4;
  localparam int LAT_B   = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_mem_responder_if #(.paddr_width_p(PADDR), .block_width_p(BLOCK), .payload_width_p(PAYLOAD))
    if_a (), if_b ();

  bp_mem_responder #(.paddr_width_p(PADDR), .block_width_p(BLOCK), .payload_width_p(PAYLOAD),
                     .mem_els_p(ELS), .latency_p(LAT_A))
    dut_a (.clk_i(clk), .reset_n_i(reset_n), .mem_if(if_a));

  bp_mem_responder #(.paddr_width_p(PADDR), .block_width_p(BLOCK), .payload_width_p(PAYLOAD),
                     .mem_els_p(ELS), .latency_p(LAT_B))
    dut_b (.clk_i(clk), .reset_n_i(reset_n), .mem_if(if_b));

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] model [2][ELS*BB];

  function automatic int lat(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic drive(input int d, input logic [MSG_W-1:0] m, input logic v);
    if (d == 0) begin if_a.mem_cmd_i = m; if_a.mem_cmd_v_i = v; end
    else        begin if_b.mem_cmd_i = m; if_b.mem_cmd_v_i = v; end
  endtask

  task automatic set_yumi(input int d, input logic y);
    if (d == 0) if_a.mem_resp_yumi_i = y;
    else        if_b.mem_resp_yumi_i = y;
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? if_a.mem_cmd_ready_o : if_b.mem_cmd_ready_o;
  endfunction

  function automatic logic get_v(input int d);
    return (d == 0) ? if_a.mem_resp_v_o : if_b.mem_resp_v_o;
  endfunction

  function automatic logic [MSG_W-1:0] get_resp(input int d);
    return (d == 0) ? if_a.mem_resp_o : if_b.mem_resp_o;
  endfunction

  function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [2:0] sz,
                                          input logic [PADDR-1:0] addr,
                                          input logic [PAYLOAD-1:0] pl,
                                          input logic [BLOCK-1:0] data);
    return {data, pl, addr, sz, t};
  endfunction

  function automatic logic [BLOCK-1:0] rand_block();
    logic [BLOCK-1:0] r;
    for (int i = 0; i < BLOCK/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Applies one command to the byte model and returns the response it must produce.
  function automatic logic [MSG_W-1:0] model_apply(input int d, input logic [MSG_W-1:0] m);
    logic [3:0]         t;
    logic [2:0]         sz;
    logic [PADDR-1:0]   addr;
    logic [BLOCK-1:0]   data, rdata;
    int                 blk, off, n;
    t     = m[3:0];
    sz    = m[6:4];
    addr  = m[7 +: PADDR];
    data  = m[MSG_W-1 -: BLOCK];
    blk   = int'((addr / BB) % ELS);
    n     = 1 << sz;
    if (n > BB) n = BB;
    off   = int'(addr % BB);
    off   = off - (off % n);
    rdata = '0;
    if (t == 4'd1 || t == 4'd3) begin
      for (int j = 0; j < n; j++) model[d][blk*BB + off + j] = data[j*8 +: 8];
    end else if (t == 4'd0 || t == 4'd2) begin
      for (int i = 0; i < BB; i++) rdata[i*8 +: 8] = model[d][blk*BB + off + (i % n)];
    end
    return {rdata, m[MSG_W-BLOCK-1:0]};
  endfunction

  task automatic issue(input int d, input logic [MSG_W-1:0] m, input string name);
    tests_run++;
    if (get_ready(d) !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready before accept: got %b want 1", name, get_ready(d));
    end
    drive(d, m, 1'b1);
    @(posedge clk); #1;
    drive(d, m, 1'b0);
  endtask

  task automatic await_v(input int d, input string name, output bit ok);
    int n;
    n = 0;
    while (get_v(d) !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (get_v(d) === 1'b1);
    tests_run++;
    if (n != lat(d)) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, n, lat(d));
    end
  endtask

  task automatic take(input int d, input string name);
    set_yumi(d, 1'b1);
    @(posedge clk); #1;
    set_yumi(d, 1'b0);
    tests_run++;
    if (get_ready(d) !== 1'b1 || get_v(d) !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after yumi: got ready=%b v=%b want ready=1 v=0", name, get_ready(d), get_v(d));
    end
  endtask

  task automatic run_cmd(input int d, input logic [MSG_W-1:0] m, input string name,
                         output logic [MSG_W-1:0] got);
    logic [MSG_W-1:0] exp;
    bit ok;
    exp = model_apply(d, m);
    issue(d, m, name);
    await_v(d, name, ok);
    got = get_resp(d);
    if (ok) begin
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s resp: got %h want %h", name, got, exp);
      end
      take(d, name);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (get_ready(d) !== 1'b1 || get_v(d) !== 1'b0 || get_resp(d) !== '0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: got ready=%b v=%b resp=%h want 1 0 0",
                 d, get_ready(d), get_v(d), get_resp(d));
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (get_ready(d) !== 1'b1 || get_v(d) !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset dut%0d: got ready=%b v=%b want 1 0", d, get_ready(d), get_v(d));
      end
    end
  endtask

  task automatic preload();
    logic [MSG_W-1:0] got;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < ELS; b++)
        run_cmd(d, mk(4'd1, 3'd6, PADDR'(b*BB), PAYLOAD'($urandom), rand_block()), "preload", got);
  endtask

  task automatic test_write_read();
    logic [MSG_W-1:0] got;
    logic [BLOCK-1:0] data;
    data = rand_block();
    data[63:0] = 64'hDEADBEEF_CAFEF00D;
    run_cmd(0, mk(4'd3, 3'd3, 40'h80_0000_0008, 16'h00a5, data), "uc_wr_8B", got);
    tests_run++;
    if (got[MSG_W-1 -: BLOCK] !== '0) begin
      tests_failed++;
      $display("FAIL uc_wr_8B data: got %h want 0", got[MSG_W-1 -: BLOCK]);
    end
    run_cmd(0, mk(4'd2, 3'd3, 40'h80_0000_0008, 16'h005a, rand_block()), "uc_rd_8B", got);
    tests_run++;
    if (got[MSG_W-1 -: BLOCK] !== {8{64'hDEADBEEF_CAFEF00D}}) begin
      tests_failed++;
      $display("FAIL uc_rd_8B replicate: got %h want 8x deadbeefcafef00d", got[MSG_W-1 -: BLOCK]);
    end
  endtask

  task automatic test_full_block();
    logic [MSG_W-1:0] got;
    logic [BLOCK-1:0] pat;
    for (int i = 0; i < BB; i++) pat[i*8 +: 8] = 8'(i);
    run_cmd(0, mk(4'd1, 3'd6, 40'h40, 16'h1234, pat), "wr_block", got);
    run_cmd(0, mk(4'd0, 3'd6, 40'h40, 16'h1234, rand_block()), "rd_block", got);
    tests_run++;
    if (got[MSG_W-1 -: BLOCK] !== pat || got[7+PADDR +: PAYLOAD] !== 16'h1234) begin
      tests_failed++;
      $display("FAIL rd_block data/payload: got %h / %h want ramp / 1234",
               got[MSG_W-1 -: BLOCK], got[7+PADDR +: PAYLOAD]);
    end
  endtask

  task automatic test_wrap();
    logic [MSG_W-1:0] got;
    logic [BLOCK-1:0] data;
    data = rand_block();
    run_cmd(0, mk(4'd1, 3'd6, 40'h0, 16'h0001, data), "wrap_wr", got);
    run_cmd(0, mk(4'd0, 3'd6, 40'h1000, 16'h0002, '0), "wrap_rd", got);
    tests_run++;
    if (got[MSG_W-1 -: BLOCK] !== data) begin
      tests_failed++;
      $display("FAIL wrap_rd data: got %h want %h", got[MSG_W-1 -: BLOCK], data);
    end
  endtask

  task automatic test_backpressure();
    logic [MSG_W-1:0] m, held, exp, exp2, held_resp;
    bit ok;
    m    = mk(4'd0, 3'd4, PADDR'({$urandom, $urandom}), 16'h0bb0, rand_block());
    held = mk(4'd3, 3'd5, PADDR'({$urandom, $urandom}), 16'h0cc0, rand_block());
    exp  = model_apply(0, m);
    issue(0, m, "bp_rd");
    await_v(0, "bp_rd", ok);
    held_resp = get_resp(0);
    tests_run++;
    if (held_resp !== exp) begin
      tests_failed++;
      $display("FAIL bp_rd resp: got %h want %h", held_resp, exp);
    end
    drive(0, held, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (get_v(0) !== 1'b1 || get_resp(0) !== exp || get_ready(0) !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d: got v=%b ready=%b resp=%h want v=1 ready=0 resp=%h",
                 c, get_v(0), get_ready(0), get_resp(0), exp);
      end
    end
    take(0, "bp_release");
    exp2 = model_apply(0, held);
    @(posedge clk); #1;
    drive(0, held, 1'b0);
    await_v(0, "bp_held_cmd", ok);
    if (ok) begin
      tests_run++;
      if (get_resp(0) !== exp2) begin
        tests_failed++;
        $display("FAIL bp_held_cmd resp: got %h want %h", get_resp(0), exp2);
      end
      take(0, "bp_held_cmd");
    end
  endtask

  task automatic test_random(input int d, input int count);
    logic [MSG_W-1:0] got;
    for (int k = 0; k < count; k++)
      run_cmd(d, mk(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                    PADDR'({$urandom, $urandom}), PAYLOAD'($urandom), rand_block()),
              "random", got);
  endtask

  task automatic test_back_to_back();
    localparam int K = 12;
    logic [MSG_W-1:0] cmds [K];
    logic [MSG_W-1:0] exp;
    for (int k = 0; k < K; k++)
      cmds[k] = mk(4'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                   PADDR'({$urandom, $urandom}), PAYLOAD'($urandom), rand_block());
    tests_run++;
    if (get_ready(1) !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b start ready: got %b want 1", get_ready(1));
    end
    drive(1, cmds[0], 1'b1);
    for (int k = 0; k < K; k++) begin
      exp = model_apply(1, cmds[k]);
      @(posedge clk); #1;
      tests_run++;
      if (get_v(1) !== 1'b1 || get_ready(1) !== 1'b0 || get_resp(1) !== exp) begin
        tests_failed++;
        $display("FAIL b2b resp %0d: got v=%b ready=%b resp=%h want v=1 ready=0 resp=%h",
                 k, get_v(1), get_ready(1), get_resp(1), exp);
      end
      set_yumi(1, 1'b1);
      if (k < K-1) drive(1, cmds[k+1], 1'b1);
      else         drive(1, '0, 1'b0);
      @(posedge clk); #1;
      set_yumi(1, 1'b0);
      tests_run++;
      if (get_ready(1) !== 1'b1 || get_v(1) !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b reaccept %0d: got ready=%b v=%b want 1 0", k, get_ready(1), get_v(1));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [MSG_W-1:0] got, wr;
    logic [BLOCK-1:0] data;
    logic saw_v;
    data = rand_block();
    wr = mk(4'd3, 3'd6, 40'h140, 16'h0777, data);
    void'(model_apply(0, wr));
    issue(0, wr, "rst_wr");
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (get_ready(0) !== 1'b1 || get_v(0) !== 1'b0 || get_resp(0) !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_wait: got ready=%b v=%b resp=%h want 1 0 0",
               get_ready(0), get_v(0), get_resp(0));
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    saw_v = 1'b0;
    for (int c = 0; c < LAT_A + 4; c++) begin
      @(posedge clk); #1;
      saw_v = saw_v | get_v(0);
    end
    tests_run++;
    if (saw_v !== 1'b0 || get_ready(0) !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_dropped: got saw_v=%b ready=%b want 0 1", saw_v, get_ready(0));
    end
    run_cmd(0, mk(4'd0, 3'd6, 40'h140, 16'h0001, '0), "rst_readback", got);
    tests_run++;
    if (got[MSG_W-1 -: BLOCK] !== data) begin
      tests_failed++;
      $display("FAIL rst_readback data: got %h want %h", got[MSG_W-1 -: BLOCK], data);
    end
    run_cmd(0, mk(4'd5, 3'd6, 40'h140, 16'h0abc, rand_block()), "amo", got);
    tests_run++;
    if (got[MSG_W-1 -: BLOCK] !== '0) begin
      tests_failed++;
      $display("FAIL amo data: got %h want 0", got[MSG_W-1 -: BLOCK]);
    end
    run_cmd(0, mk(4'd0, 3'd6, 40'h140, 16'h0002, '0), "amo_readback", got);
    tests_run++;
    if (got[MSG_W-1 -: BLOCK] !== data) begin
      tests_failed++;
      $display("FAIL amo_readback data: got %h want %h", got[MSG_W-1 -: BLOCK], data);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    set_yumi(0, 1'b0);
    set_yumi(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    preload();
    test_write_read();
    test_full_block();
    test_wrap();
    test_backpressure();
    test_random(0, 60);
    test_random(1, 40);
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
